// File: rtl/pnr_photon_counter_if.sv
// Trigger, configuration and result signals of the photon-number counter.
// The master side is the trigger/config source and result sink; the slave side is the counter.
interface pnr_photon_counter_if #(
    parameter int DW  = 14,
    parameter int LW  = 16,
    parameter int AW  = 32,
    parameter int NTH = 8,
    parameter int CW  = 4
);
    logic                   enable_i;
    logic signed [DW-1:0]   sig_i;
    logic                   delayed_trigger_i;
    logic signed [DW-1:0]   baseline_i;
    logic [LW-1:0]          integ_len_i;
    logic                   invert_i;
    logic [NTH*AW-1:0]      thresholds_i;
    logic                   busy_o;
    logic                   pnr_valid_o;
    logic [CW-1:0]          pnr_count_o;
    logic signed [AW-1:0]   pnr_sum_o;
    logic [15:0]            drop_cnt_o;

    modport master (
        output enable_i, sig_i, delayed_trigger_i, baseline_i,
               integ_len_i, invert_i, thresholds_i,
        input  busy_o, pnr_valid_o, pnr_count_o, pnr_sum_o, drop_cnt_o
    );

    modport slave (
        input  enable_i, sig_i, delayed_trigger_i, baseline_i,
               integ_len_i, invert_i, thresholds_i,
        output busy_o, pnr_valid_o, pnr_count_o, pnr_sum_o, drop_cnt_o
    );
endinterface

// File: rtl/pnr_photon_counter.sv
// Integrates baseline-subtracted ADC samples over a triggered window and
// grades the integral against a threshold ladder into a photon number.
module pnr_photon_counter #(
    parameter int DW  = 14,
    parameter int LW  = 16,
    parameter int AW  = 32,
    parameter int NTH = 8,
    parameter int CW  = 4
) (
    input logic              ADC_CLK,
    input logic              rstn_i,
    pnr_photon_counter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, INTEG, DONE} state_t;

    state_t               state, state_next;
    logic signed [AW-1:0] acc, acc_next;
    logic [LW-1:0]        rem, rem_next;
    logic                 inv_lat, inv_next;
    logic                 busy;
    logic                 pnr_valid;
    logic [CW-1:0]        pnr_count;
    logic signed [AW-1:0] pnr_sum;
    logic [15:0]          drop_cnt;
    logic [CW-1:0]        thr_count;

    // The difference of two DW-bit samples and its negation both fit in DW+1 bits.
    function automatic logic signed [AW-1:0] sample_term(
        input logic signed [DW-1:0] s,
        input logic signed [DW-1:0] b,
        input logic                 inv
    );
        logic signed [DW:0] d;
        d = $signed({s[DW-1], s}) - $signed({b[DW-1], b});
        if (inv)
            d = -d;
        return AW'(d);
    endfunction

    function automatic logic [CW-1:0] count_hits(
        input logic signed [AW-1:0] a,
        input logic [NTH*AW-1:0]    thr
    );
        logic [CW-1:0]        n;
        logic signed [AW-1:0] t;
        n = '0;
        for (int k = 0; k < NTH; k++) begin
            t = thr[k*AW +: AW];
            if (a >= t)
                n = n + CW'(1);
        end
        return n;
    endfunction

    always_comb begin
        state_next = state;
        acc_next   = acc;
        rem_next   = rem;
        inv_next   = inv_lat;
        if (!bus.enable_i) begin
            state_next = IDLE;
            acc_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.delayed_trigger_i) begin
                        inv_next   = bus.invert_i;
                        rem_next   = (bus.integ_len_i == '0) ? LW'(1) : bus.integ_len_i;
                        acc_next   = sample_term(bus.sig_i, bus.baseline_i, bus.invert_i);
                        state_next = (bus.integ_len_i > LW'(1)) ? INTEG : DONE;
                    end
                end
                INTEG: begin
                    acc_next = acc + sample_term(bus.sig_i, bus.baseline_i, inv_lat);
                    rem_next = rem - LW'(1);
                    // rem still counts the trigger-cycle sample, so 2 means this add is the last
                    if (rem == LW'(2))
                        state_next = DONE;
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        thr_count = count_hits(acc, bus.thresholds_i);
    end

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            acc     <= '0;
            rem     <= '0;
            inv_lat <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            rem     <= rem_next;
            inv_lat <= inv_next;
            busy    <= (state_next != IDLE);
        end
    end

    // Result registers hold until the next completed window.
    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            pnr_valid <= 1'b0;
            pnr_count <= '0;
            pnr_sum   <= '0;
            drop_cnt  <= '0;
        end else begin
            pnr_valid <= (state == DONE) && bus.enable_i;
            if ((state == DONE) && bus.enable_i) begin
                pnr_count <= thr_count;
                pnr_sum   <= acc;
            end
            if (bus.delayed_trigger_i && bus.enable_i && (state != IDLE) && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign bus.busy_o      = busy;
    assign bus.pnr_valid_o = pnr_valid;
    assign bus.pnr_count_o = pnr_count;
    assign bus.pnr_sum_o   = pnr_sum;
    assign bus.drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_pnr_photon_counter.sv
// Directed bench for pnr_photon_counter: windowing, latency, thresholds,
// dropped triggers, enable abort, async reset and drop-counter saturation.
module tb_pnr_photon_counter;

    localparam int DW  = 14;
    localparam int LW  = 16;
    localparam int AW  = 32;
    localparam int NTH = 8;
    localparam int CW  = 4;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;

    pnr_photon_counter_if #(.DW(DW), .LW(LW), .AW(AW), .NTH(NTH), .CW(CW)) bus ();

    pnr_photon_counter #(.DW(DW), .LW(LW), .AW(AW), .NTH(NTH), .CW(CW)) dut (
        .ADC_CLK (clk),
        .rstn_i  (rstn),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ladder(input int base, input int step);
        logic [NTH*AW-1:0] v;
        for (int k = 0; k < NTH; k++)
            v[k*AW +: AW] = AW'(base + step * k);
        bus.thresholds_i = v;
    endtask

    task automatic set_all_thr(input logic [AW-1:0] t);
        logic [NTH*AW-1:0] v;
        for (int k = 0; k < NTH; k++)
            v[k*AW +: AW] = t;
        bus.thresholds_i = v;
    endtask

    // Drives trigger/enable per cycle from masks; records valid and busy after each edge.
    task automatic run_cycles(input int n, input logic [63:0] trig_m, input logic [63:0] en_m,
                              output logic [63:0] vm, output logic [63:0] bm);
        vm = '0;
        bm = '0;
        for (int i = 0; i < n; i++) begin
            bus.delayed_trigger_i = trig_m[i];
            bus.enable_i          = en_m[i];
            @(posedge clk);
            #1;
            vm[i] = bus.pnr_valid_o;
            bm[i] = bus.busy_o;
        end
        bus.delayed_trigger_i = 1'b0;
        bus.enable_i          = 1'b1;
    endtask

    task automatic test_reset();
        rstn                  = 1'b0;
        bus.enable_i          = 1'b1;
        bus.delayed_trigger_i = 1'b0;
        bus.sig_i             = '0;
        bus.baseline_i        = '0;
        bus.integ_len_i       = LW'(1);
        bus.invert_i          = 1'b0;
        set_ladder(250, 100);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", bus.busy_o); end
        n_cmp++; if (bus.pnr_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", bus.pnr_valid_o); end
        n_cmp++; if (bus.pnr_count_o !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.pnr_count_o); end
        n_cmp++; if (bus.pnr_sum_o !== 32'd0) begin n_bad++; $display("FAIL reset_sum: got %0h expected 0", bus.pnr_sum_o); end
        n_cmp++; if (bus.drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d expected 0", bus.drop_cnt_o); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_basic_window();
        logic [63:0] vm, bm;
        bus.sig_i       = 14'sd100;
        bus.baseline_i  = '0;
        bus.integ_len_i = LW'(4);
        bus.invert_i    = 1'b0;
        set_ladder(250, 100);
        run_cycles(8, 64'h1, '1, vm, bm);
        n_cmp++; if (vm !== 64'h10) begin n_bad++; $display("FAIL basic_valid_timing: got %0h expected 10", vm); end
        n_cmp++; if (bm !== 64'hF) begin n_bad++; $display("FAIL basic_busy: got %0h expected f", bm); end
        n_cmp++; if (bus.pnr_sum_o !== 32'sd400) begin n_bad++; $display("FAIL basic_sum: got %0d expected 400", bus.pnr_sum_o); end
        n_cmp++; if (bus.pnr_count_o !== 4'd2) begin n_bad++; $display("FAIL basic_count: got %0d expected 2", bus.pnr_count_o); end
    endtask

    task automatic test_len_zero_invert();
        logic [63:0] vm, bm;
        logic signed [AW-1:0] exp_sum;
        exp_sum         = -32'sd50;
        bus.sig_i       = -14'sd50;
        bus.baseline_i  = -14'sd100;
        bus.integ_len_i = '0;
        bus.invert_i    = 1'b1;
        run_cycles(5, 64'h1, '1, vm, bm);
        bus.invert_i    = 1'b0;
        n_cmp++; if (vm !== 64'h2) begin n_bad++; $display("FAIL len0_valid_timing: got %0h expected 2", vm); end
        n_cmp++; if (bus.pnr_sum_o !== exp_sum) begin n_bad++; $display("FAIL len0_sum: got %0d expected -50", bus.pnr_sum_o); end
        n_cmp++; if (bus.pnr_count_o !== 4'd0) begin n_bad++; $display("FAIL len0_count: got %0d expected 0", bus.pnr_count_o); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vm, bm;
        bus.sig_i       = 14'sd100;
        bus.baseline_i  = '0;
        bus.integ_len_i = LW'(10);
        set_ladder(250, 100);
        // Triggers at offsets 0, 3 (INTEG) and 10 (DONE); the window result lands at offset 10.
        run_cycles(11, 64'h409, '1, vm, bm);
        n_cmp++; if (vm !== 64'h400) begin n_bad++; $display("FAIL b2b_first_valid: got %0h expected 400", vm); end
        n_cmp++; if (bus.pnr_sum_o !== 32'sd1000) begin n_bad++; $display("FAIL b2b_first_sum: got %0d expected 1000", bus.pnr_sum_o); end
        n_cmp++; if (bus.pnr_count_o !== 4'd8) begin n_bad++; $display("FAIL b2b_first_count: got %0d expected 8", bus.pnr_count_o); end
        n_cmp++; if (bus.drop_cnt_o !== 16'd2) begin n_bad++; $display("FAIL b2b_drops: got %0d expected 2", bus.drop_cnt_o); end
        bus.sig_i = 14'sd30;
        run_cycles(12, 64'h1, '1, vm, bm);
        n_cmp++; if (vm !== 64'h400) begin n_bad++; $display("FAIL b2b_second_valid: got %0h expected 400", vm); end
        n_cmp++; if (bus.pnr_sum_o !== 32'sd300) begin n_bad++; $display("FAIL b2b_second_sum: got %0d expected 300", bus.pnr_sum_o); end
        n_cmp++; if (bus.pnr_count_o !== 4'd1) begin n_bad++; $display("FAIL b2b_second_count: got %0d expected 1", bus.pnr_count_o); end
    endtask

    task automatic test_thresholds();
        logic [63:0] vm, bm;
        bus.sig_i       = 14'sd123;
        bus.baseline_i  = '0;
        bus.integ_len_i = LW'(1);
        set_all_thr(32'h8000_0000);
        run_cycles(4, 64'h1, '1, vm, bm);
        n_cmp++; if (bus.pnr_count_o !== 4'd8) begin n_bad++; $display("FAIL thr_min_count: got %0d expected 8", bus.pnr_count_o); end
        set_all_thr(32'h7FFF_FFFF);
        run_cycles(4, 64'h1, '1, vm, bm);
        n_cmp++; if (bus.pnr_count_o !== 4'd0) begin n_bad++; $display("FAIL thr_max_count: got %0d expected 0", bus.pnr_count_o); end
        // Descending ladder 950..250 against an integral of 400.
        bus.sig_i       = 14'sd100;
        bus.integ_len_i = LW'(4);
        set_ladder(950, -100);
        run_cycles(7, 64'h1, '1, vm, bm);
        n_cmp++; if (bus.pnr_count_o !== 4'd2) begin n_bad++; $display("FAIL thr_unsorted_count: got %0d expected 2", bus.pnr_count_o); end
        set_ladder(250, 100);
    endtask

    task automatic test_enable_abort();
        logic [63:0] vm, bm;
        bus.sig_i       = 14'sd10;
        bus.baseline_i  = '0;
        bus.integ_len_i = LW'(8);
        // Enable low at offsets 2..5, with a trigger at offset 4 while disabled.
        run_cycles(12, 64'h11, ~64'h3C, vm, bm);
        n_cmp++; if (vm !== 64'h0) begin n_bad++; $display("FAIL abort_no_valid: got %0h expected 0", vm); end
        n_cmp++; if (bm !== 64'h3) begin n_bad++; $display("FAIL abort_busy: got %0h expected 3", bm); end
        n_cmp++; if (bus.pnr_sum_o !== 32'sd400) begin n_bad++; $display("FAIL abort_sum_held: got %0d expected 400", bus.pnr_sum_o); end
        n_cmp++; if (bus.drop_cnt_o !== 16'd2) begin n_bad++; $display("FAIL abort_drops: got %0d expected 2", bus.drop_cnt_o); end
        bus.sig_i       = 14'sd7;
        bus.integ_len_i = LW'(2);
        run_cycles(5, 64'h1, '1, vm, bm);
        n_cmp++; if (vm !== 64'h4) begin n_bad++; $display("FAIL reenable_valid: got %0h expected 4", vm); end
        n_cmp++; if (bus.pnr_sum_o !== 32'sd14) begin n_bad++; $display("FAIL reenable_sum: got %0d expected 14", bus.pnr_sum_o); end
    endtask

    task automatic test_async_reset();
        logic [63:0] vm, bm;
        bus.sig_i       = 14'sd20;
        bus.integ_len_i = LW'(8);
        run_cycles(3, 64'h1, '1, vm, bm);
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %0b expected 0", bus.busy_o); end
        n_cmp++; if (bus.pnr_sum_o !== 32'd0) begin n_bad++; $display("FAIL arst_sum: got %0d expected 0", bus.pnr_sum_o); end
        n_cmp++; if (bus.drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL arst_drop: got %0d expected 0", bus.drop_cnt_o); end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        run_cycles(10, 64'h0, '1, vm, bm);
        n_cmp++; if (vm !== 64'h0) begin n_bad++; $display("FAIL arst_no_valid: got %0h expected 0", vm); end
        n_cmp++; if (bm !== 64'h0) begin n_bad++; $display("FAIL arst_idle: got %0h expected 0", bm); end
    endtask

    task automatic test_drop_saturation();
        logic [63:0] vm, bm;
        bus.sig_i       = 14'sd5;
        bus.integ_len_i = LW'(4);
        force dut.drop_cnt = 16'hFFFE;
        #1;
        release dut.drop_cnt;
        run_cycles(7, 64'h7, '1, vm, bm);
        n_cmp++; if (bus.drop_cnt_o !== 16'hFFFF) begin n_bad++; $display("FAIL drop_saturate: got %0h expected ffff", bus.drop_cnt_o); end
        n_cmp++; if (vm !== 64'h10) begin n_bad++; $display("FAIL drop_sat_valid: got %0h expected 10", vm); end
        n_cmp++; if (bus.pnr_sum_o !== 32'sd20) begin n_bad++; $display("FAIL drop_sat_sum: got %0d expected 20", bus.pnr_sum_o); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic_window();
        test_len_zero_invert();
        test_back_to_back();
        test_thresholds();
        test_enable_abort();
        test_async_reset();
        test_drop_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pnr_photon_counter.md
Name: pnr_photon_counter

Overview:
Consumer of the delayed trigger produced by the PNR trigger block. On each accepted delayed trigger it integrates the baseline-subtracted ADC signal over a programmable window. It compares the integral against a threshold ladder and emits a photon-number result with a one-cycle valid strobe. It sits in the ADC_CLK domain, between the trigger logic and the result FIFO or register bank.

Parameters:
DW, 14, ADC sample width (signed, two's complement)
LW, 16, integration-length width (max window 2^LW-1 samples)
AW, 32, accumulator / threshold width (signed); must be >= DW+1+LW
NTH, 8, number of photon-number thresholds
CW, 4, count width; must be >= clog2(NTH+1)

Ports:
ADC_CLK  in  1  sample clock
rstn_i  in  1  asynchronous active-low reset
enable_i  in  1  block enable; low aborts activity synchronously
sig_i  in  DW  signed ADC sample to integrate
delayed_trigger_i  in  1  one-cycle start pulse from the trigger block
baseline_i  in  DW  signed baseline subtracted from every sample
integ_len_i  in  LW  window length in samples; 0 is treated as 1
invert_i  in  1  1 = accumulate -(sig-baseline), for negative-going pulses
thresholds_i  in  NTH*AW  packed signed thresholds; thr[k] = bits [k*AW +: AW]
busy_o  out  1  high in INTEG and DONE
pnr_valid_o  out  1  one-cycle result strobe
pnr_count_o  out  CW  photon number (0..NTH)
pnr_sum_o  out  AW  signed integral of the last result
drop_cnt_o  out  16  saturating count of triggers ignored while busy

Behaviour:
- Reset (async, rstn_i=0): state IDLE; accumulator 0; busy_o=0, pnr_valid_o=0, pnr_count_o=0, pnr_sum_o=0, drop_cnt_o=0.
- Sample term: d = sext(sig_i) - sext(baseline_i), computed at DW+1 bits with no overflow. The term added is d, or -d when invert is latched. The term is sign-extended to AW.
- FSM has three states:
  - IDLE: on delayed_trigger_i && enable_i, latch invert_i and max(integ_len_i,1) into the remaining counter. Set acc <= term of the current sig_i; that trigger-cycle sample is sample 0. Go to INTEG when the latched length is > 1, otherwise go to DONE.
  - INTEG: each cycle acc += term and remaining decrements. The cycle that adds the last sample goes to DONE. A window of length L uses the samples at trigger cycles T..T+L-1.
  - DONE (one cycle): count = number of k in 0..NTH-1 with acc >= thr[k] (signed). thresholds_i is sampled in this cycle. Register pnr_count_o <= count, pnr_sum_o <= acc and pnr_valid_o <= 1, then go to IDLE.
- Latency: trigger at cycle T, length L gives pnr_valid_o high in cycle T+L+1, for exactly 1 cycle.
- pnr_count_o and pnr_sum_o hold their value until the next result.
- Thresholds are not required to be ascending. Count is the number of thresholds satisfied; the block does not sort them.
- baseline_i is used live every cycle; software changes it only while idle.
- busy_o = (state != IDLE), registered alongside state.
- A trigger in INTEG or DONE is ignored and drop_cnt_o increments, saturating at 16'hFFFF.
- A trigger in the same cycle pnr_valid_o is high is accepted, because the state is already IDLE then. Back-to-back windows are therefore spaced L+1 cycles apart.
- enable_i=0: state goes to IDLE on the next edge and acc is cleared. No pnr_valid_o is produced for an aborted window. Triggers are ignored and not counted as drops. Registered outputs and drop_cnt_o keep their values.
- Async reset mid-window: everything returns to reset values immediately and no result is produced.
- Width: AW >= DW+1+LW guarantees the accumulator cannot overflow, so there is no saturation logic.

Test Plan:
- baseline=0, L=4, invert=0, sig=100 constant, thr={250,350,450,...}, trigger at T -> pnr_valid_o at T+5 only, pnr_sum_o=400, pnr_count_o=2.
- L=0, sig=-50, baseline=-100, invert=1 -> length treated as 1, pnr_valid_o at T+2, pnr_sum_o=-50, count=0 with thr all >= 0.
- L=10, second trigger at T+3 and third at T+10 (DONE) -> both ignored, drop_cnt_o=2, single valid at T+11; fourth trigger at T+11 accepted, valid at T+22.
- thr all = -(2^31) (AW=32 minimum), any input -> pnr_count_o=8; thr=all max positive -> 0.
- enable_i drops at T+2 of an L=8 window -> no pnr_valid_o, busy_o=0 at T+3; re-enable and trigger -> normal result with fresh acc.
- Assert rstn_i low at T+3 of an L=8 window -> outputs immediately 0, no valid; drop_cnt_o pre-forced to 65535 with extra dropped trigger stays 65535.
